// File: rtl/alu_rf_issue.sv
// alu_rf_issue: operand-issue stage that sits directly in front of alu32.
// Commands arrive over a valid/ready handshake. Operands are read from an
// internal register file and registered into S1, which drives alu32. The ALU
// result is captured into S2, written back, and offered downstream over
// valid/ready. Throughput is one op per cycle, with full backpressure.
// Optional build macro: ALU_RF_ISSUE_PERF_EN adds the perf_issued and
// perf_stall counters.
module alu_rf_issue #(
  parameter  int NREG = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [RW-1:0] cmd_rd,
  input  logic [RW-1:0] cmd_rs1,
  input  logic [RW-1:0] cmd_rs2,
  input  logic          cmd_imm_en,
  input  logic [31:0]   cmd_imm,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [3:0]    alu_op,
  input  logic [31:0]   alu_y,
  input  logic [3:0]    alu_flags,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_data,
  output logic [RW-1:0] res_rd,
  output logic [3:0]    res_flags,
  output logic          res_err
`ifdef ALU_RF_ISSUE_PERF_EN
  ,
  output logic [31:0]   perf_issued,
  output logic [31:0]   perf_stall
`endif
);

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_OP_LAST = 4'd8;

  logic [31:0]   rf_q [NREG];

  logic          s1_valid_q;
  logic [31:0]   s1_a_q;
  logic [31:0]   s1_b_q;
  logic [3:0]    s1_op_q;
  logic [RW-1:0] s1_rd_q;
  logic          s1_err_q;

  logic          res_valid_q;
  logic [31:0]   res_data_q;
  logic [RW-1:0] res_rd_q;
  logic [3:0]    res_flags_q;
  logic          res_err_q;

  logic          s1_adv;
  logic          accept;
  logic          byp_ok;
  logic          wb_en;
  logic          cmd_illegal;
  logic [31:0]   opa_d;
  logic [31:0]   opb_d;

  // Handshake: S1 moves into S2 whenever S2 is empty or being drained.
  always_comb begin
    s1_adv      = s1_valid_q & (~res_valid_q | res_ready);
    cmd_ready   = ~s1_valid_q | s1_adv;
    accept      = cmd_valid & cmd_ready;
    wb_en       = s1_adv & ~s1_err_q & (s1_rd_q != '0);
    byp_ok      = wb_en;
    cmd_illegal = cmd_op > ALU_OP_LAST;
  end

  // Operand select: r0 is hard zero; forward alu_y when S1 writes the source
  // on this same edge, because the regfile still holds the older value.
  always_comb begin
    opa_d = '0;
    opb_d = '0;
    if (cmd_rs1 != '0) begin
      if (byp_ok && (s1_rd_q == cmd_rs1)) opa_d = alu_y;
      else                                opa_d = rf_q[cmd_rs1];
    end
    if (cmd_imm_en) begin
      opb_d = cmd_imm;
    end else if (cmd_rs2 != '0) begin
      if (byp_ok && (s1_rd_q == cmd_rs2)) opb_d = alu_y;
      else                                opb_d = rf_q[cmd_rs2];
    end
  end

  // S1 operand stage; illegal opcodes still flow through the pipe, but they
  // drive ADD into the ALU and carry an error marker.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= ALU_ADD;
      s1_rd_q    <= '0;
      s1_err_q   <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= opa_d;
      s1_b_q     <= opb_d;
      s1_op_q    <= cmd_illegal ? ALU_ADD : cmd_op;
      s1_rd_q    <= cmd_rd;
      s1_err_q   <= cmd_illegal;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // S2 result stage; it holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_flags_q <= '0;
      res_err_q   <= 1'b0;
    end else if (s1_adv) begin
      res_valid_q <= 1'b1;
      res_data_q  <= s1_err_q ? 32'd0 : alu_y;
      res_flags_q <= s1_err_q ? 4'd0 : alu_flags;
      res_rd_q    <= s1_rd_q;
      res_err_q   <= s1_err_q;
    end else if (res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  // Register file write-back happens on the same edge that S1 advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[s1_rd_q] <= alu_y;
    end
  end

  assign alu_a     = s1_a_q;
  assign alu_b     = s1_b_q;
  assign alu_op    = s1_op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;
  assign res_flags = res_flags_q;
  assign res_err   = res_err_q;

`ifdef ALU_RF_ISSUE_PERF_EN
  logic [31:0] perf_issued_q;
  logic [31:0] perf_stall_q;

  // Saturating counters for accepted commands and stalled request cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (accept && (perf_issued_q != 32'hFFFF_FFFF))
        perf_issued_q <= perf_issued_q + 32'd1;
      if (cmd_valid && !cmd_ready && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_rf_issue.sv
// Directed bench for alu_rf_issue. alu32 is modelled here combinationally
// with opcodes ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8, and
// flags {z,n,c,v}.
module tb_alu_rf_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic        cmd_imm_en;
  logic [31:0] cmd_imm;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_y;
  logic [3:0]  alu_flags;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_rd;
  logic [3:0]  res_flags;
  logic        res_err;
`ifdef ALU_RF_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_rf_issue #(.NREG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_flags(alu_flags),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_flags(res_flags), .res_err(res_err)
`ifdef ALU_RF_ISSUE_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  // alu32 stand-in
  logic [32:0] sum33, dif33;
  logic        c_m, v_m;
  always_comb begin
    sum33 = {1'b0, alu_a} + {1'b0, alu_b};
    dif33 = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
    c_m   = 1'b0;
    v_m   = 1'b0;
    alu_y = '0;
    case (alu_op)
      4'd0: begin alu_y = sum33[31:0]; c_m = sum33[32];
              v_m = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]); end
      4'd1: begin alu_y = dif33[31:0]; c_m = dif33[32];
              v_m = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]); end
      4'd2: alu_y = alu_a & alu_b;
      4'd3: alu_y = alu_a | alu_b;
      4'd4: alu_y = alu_a ^ alu_b;
      4'd5: alu_y = alu_a << alu_b[4:0];
      4'd6: alu_y = alu_a >> alu_b[4:0];
      4'd7: alu_y = $signed(alu_a) >>> alu_b[4:0];
      4'd8: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = '0;
    endcase
    alu_flags = {alu_y == 32'd0, alu_y[31], c_m, v_m};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic imm_en, input logic [31:0] imm);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_rd     = rd;
    cmd_rs1    = rs1;
    cmd_rs2    = rs2;
    cmd_imm_en = imm_en;
    cmd_imm    = imm;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0;
    cmd_rs2 = '0; cmd_imm_en = 1'b0; cmd_imm = '0; res_ready = 1'b1;
    tick(); tick();
    // reset state
    check("rst_res_valid", res_valid, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_alu_op", alu_op, 0);
    check("rst_res_data", res_data, 0);
    rst_n = 1'b1;

    // single ADD r1 = r0 + 10
    set_cmd(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 32'd10);
    tick();
    cmd_valid = 1'b0;
    check("t1_alu_a", alu_a, 0);
    check("t1_alu_b", alu_b, 10);
    check("t1_res_valid_early", res_valid, 0);
    tick();
    check("t1_res_valid", res_valid, 1);
    check("t1_res_data", res_data, 10);
    check("t1_res_rd", res_rd, 1);
    check("t1_res_flags", res_flags, 4'b0000);
    tick();
    check("t1_drain", res_valid, 0);

    // back-to-back with bypass
    set_cmd(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 32'd10); #1;
    check("t2_rdy0", cmd_ready, 1);
    tick();
    set_cmd(4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 32'd20); #1;
    check("t2_rdy1", cmd_ready, 1);
    tick();
    check("t2_r1", res_data, 10);
    set_cmd(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0); #1;
    check("t2_rdy2", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("t2_r2", res_data, 20);
    check("t2_r2_rd", res_rd, 2);
    tick();
    check("t2_r3", res_data, 30);
    check("t2_r3_rd", res_rd, 3);
    tick();

    // signed compare and subtract with zero flag
    set_cmd(4'd0, 3'd6, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFB);
    tick();
    set_cmd(4'd8, 3'd5, 3'd6, 3'd0, 1'b1, 32'd3);
    tick();
    check("t3_add", res_data, 32'hFFFF_FFFB);
    check("t3_add_flags", res_flags, 4'b0100);
    set_cmd(4'd1, 3'd4, 3'd6, 3'd6, 1'b0, 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("t3_slt", res_data, 1);
    check("t3_slt_rd", res_rd, 5);
    tick();
    check("t3_sub", res_data, 0);
    check("t3_sub_flags", res_flags, 4'b1010);
    tick();
    check("t3_drain", res_valid, 0);

    // backpressure: three commands offered, two accepted
    res_ready = 1'b0;
    set_cmd(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 32'd100); #1;
    check("t4_rdy_a", cmd_ready, 1);
    tick();
    set_cmd(4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 32'd200); #1;
    check("t4_rdy_b", cmd_ready, 1);
    tick();
    set_cmd(4'd0, 3'd3, 3'd0, 3'd0, 1'b1, 32'd300); #1;
    check("t4_rdy_c", cmd_ready, 0);
    check("t4_hold_data0", res_data, 100);
    tick(); #1;
    check("t4_rdy_d", cmd_ready, 0);
    check("t4_hold_data1", res_data, 100);
    check("t4_hold_rd1", res_rd, 1);
    tick(); #1;
    check("t4_rdy_e", cmd_ready, 0);
    check("t4_hold_valid", res_valid, 1);
    check("t4_hold_data2", res_data, 100);
    res_ready = 1'b1; #1;
    check("t4_rdy_rel", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("t4_out2", res_data, 200);
    check("t4_out2_rd", res_rd, 2);
    tick();
    check("t4_out3", res_data, 300);
    check("t4_out3_rd", res_rd, 3);
    tick();
    check("t4_empty", res_valid, 0);

    // illegal opcode, followed by a read of its destination
    set_cmd(4'hC, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5);
    tick();
    check("t5_alu_op", alu_op, 0);
    set_cmd(4'd0, 3'd7, 3'd1, 3'd0, 1'b1, 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("t5_err", res_err, 1);
    check("t5_data", res_data, 0);
    check("t5_flags", res_flags, 0);
    tick();
    check("t5_r1_kept", res_data, 100);
    check("t5_err_clr", res_err, 0);
    tick();

    // reset with both stages full
    set_cmd(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 32'd55);
    tick();
    set_cmd(4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 32'd66);
    res_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("t6_s2_full", res_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    check("t6_rst_valid", res_valid, 0);
    check("t6_rst_rdy", cmd_ready, 1);
    check("t6_rst_alu_b", alu_b, 0);
    set_cmd(4'd0, 3'd7, 3'd1, 3'd0, 1'b1, 32'd0);
    tick();
    set_cmd(4'd0, 3'd3, 3'd2, 3'd0, 1'b1, 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("t6_r1_zero", res_data, 0);
    check("t6_r1_rd", res_rd, 7);
    tick();
    check("t6_r2_zero", res_data, 0);
    check("t6_r2_rd", res_rd, 3);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
